// File: rtl/pc_ras.sv
// Fetch program counter: increment/stall/branch/jump plus return-address stack (RAS under `PC_RAS_EN).
// One-cycle registered latency; stall_i holds pc_o unless a control transfer wins the cycle.
module pc_ras #(
  parameter int              PC_W      = 8,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic            branch_i,
  input  logic            call_i,
  input  logic            ret_i,
  input  logic [PC_W-1:0] target_i,
  input  logic [PC_W-1:0] offset_i,
  output logic [PC_W-1:0] pc_o,
  output logic            ras_empty_o,
  output logic            ras_full_o,
  output logic            ras_ovf_o,
  output logic            ras_unf_o
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] ret_addr;
  logic            ret_win;

  assign pc_inc = pc + PC_W'(1);
  assign pc_o   = pc;

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top;
  logic [PTR_W-1:0] top_inc;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             push;
  logic             ovf;
  logic             unf;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(RAS_DEPTH));
  assign top_inc = top + PTR_W'(1);
  // An empty-stack ret loses to whatever lower request is present.
  assign ret_win = ret_i && !empty;
  assign push    = call_i && !ret_win;
  assign ret_addr = ras_mem[top];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      top   <= '1;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (ret_win) begin
        top   <= top - PTR_W'(1);
        count <= count - CNT_W'(1);
      end else if (push) begin
        // When full the write lands on the oldest slot; count saturates.
        top <= top_inc;
        if (!full) begin
          count <= count + CNT_W'(1);
        end
        ovf <= ovf | full;
      end
      unf <= unf | (ret_i && empty);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      ras_mem[top_inc] <= pc_inc;
    end
  end

  assign ras_empty_o = empty;
  assign ras_full_o  = full;
  assign ras_ovf_o   = ovf;
  assign ras_unf_o   = unf;
`else
  localparam int unused_depth = RAS_DEPTH;
  logic unused_ret;

  assign unused_ret  = ret_i;
  assign ret_win     = 1'b0;
  assign ret_addr    = '0;
  assign ras_empty_o = 1'b1;
  assign ras_full_o  = 1'b0;
  assign ras_ovf_o   = 1'b0;
  assign ras_unf_o   = 1'b0;
`endif

  always_comb begin
    pc_nxt = pc;
    if (ret_win) begin
      pc_nxt = ret_addr;
    end else if (call_i || load_i) begin
      pc_nxt = target_i;
    end else if (branch_i) begin
      pc_nxt = pc + offset_i;
    end else if (!stall_i) begin
      pc_nxt = pc_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_nxt;
    end
  end

endmodule

// File: tb/tb_pc_ras.sv
// Bench for pc_ras: directed test-plan steps then random traffic, checked against a queue-based model.
module tb_pc_ras;
  localparam int         PC_W  = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RPC   = 8'h10;

  logic       clk = 1'b0;
  logic       rst, stall, load, branch, call, ret;
  logic [7:0] target, offset;
  logic [7:0] pc;
  logic       empty, full, ovf, unf;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [7:0] m_pc;
  logic [7:0] m_ras[$];
  logic       m_ovf, m_unf;

  pc_ras #(.PC_W(PC_W), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .load_i(load), .branch_i(branch),
    .call_i(call), .ret_i(ret), .target_i(target), .offset_i(offset),
    .pc_o(pc), .ras_empty_o(empty), .ras_full_o(full), .ras_ovf_o(ovf), .ras_unf_o(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_pc = RPC;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
`ifdef PC_RAS_EN
      if (ret && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else begin
        if (ret) m_unf = 1'b1;
        if (call) begin
          if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_ras.push_back(m_pc + 8'd1);
          m_pc = target;
        end else if (load) m_pc = target;
        else if (branch) m_pc = m_pc + offset;
        else if (!stall) m_pc = m_pc + 8'd1;
      end
`else
      if (call || load) m_pc = target;
      else if (branch) m_pc = m_pc + offset;
      else if (!stall) m_pc = m_pc + 8'd1;
`endif
    end
  endtask

  task automatic step(input logic r, input logic s, input logic l, input logic b,
                      input logic c, input logic rt, input logic [7:0] t, input logic [7:0] o);
    @(negedge clk);
    rst = r; stall = s; load = l; branch = b; call = c; ret = rt; target = t; offset = o;
    @(posedge clk);
    model_step();
    #1;
    check("pc", pc, m_pc);
`ifdef PC_RAS_EN
    check("empty", 8'(empty), 8'(m_ras.size() == 0));
    check("full", 8'(full), 8'(m_ras.size() == DEPTH));
`else
    check("empty", 8'(empty), 8'd1);
    check("full", 8'(full), 8'd0);
`endif
    check("ovf", 8'(ovf), 8'(m_ovf));
    check("unf", 8'(unf), 8'(m_unf));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  initial begin
    rst = 1'b1; stall = 0; load = 0; branch = 0; call = 0; ret = 0; target = 0; offset = 0;
    m_pc = RPC; m_ovf = 0; m_unf = 0;

    do_reset();
    check("reset_pc", pc, 8'h10);
    check("reset_empty", 8'(empty), 8'd1);
    idle(); check("idle1", pc, 8'h11);
    idle(); check("idle2", pc, 8'h12);
    idle(); check("idle3", pc, 8'h13);
    do_reset();
    check("rereset_pc", pc, 8'h10);

    // Wrap-around and negative branch
    step(0, 0, 1, 0, 0, 0, 8'hFE, 8'h00); check("load_fe", pc, 8'hFE);
    idle(); check("wrap_ff", pc, 8'hFF);
    idle(); check("wrap_00", pc, 8'h00);
    idle(); check("wrap_01", pc, 8'h01);
    step(0, 0, 0, 1, 0, 0, 8'h00, 8'hFE); check("branch_neg", pc, 8'hFF);
    step(0, 1, 0, 1, 0, 0, 8'h00, 8'h03); check("branch_over_stall", pc, 8'h02);
    step(0, 1, 0, 0, 0, 0, 8'h00, 8'h00); check("stall_hold", pc, 8'h02);

`ifdef PC_RAS_EN
    // Nested calls
    step(0, 0, 1, 0, 0, 0, 8'h05, 8'h00);
    step(0, 0, 0, 0, 1, 0, 8'h40, 8'h00); check("call1", pc, 8'h40);
    step(0, 0, 0, 0, 1, 0, 8'h80, 8'h00); check("call2", pc, 8'h80);
    step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00); check("ret1", pc, 8'h41);
    step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00); check("ret2", pc, 8'h06);
    check("nest_empty", 8'(empty), 8'd1);
    check("nest_flags", {6'd0, ovf, unf}, 8'd0);

    // Overflow then underflow
    do_reset();
    step(0, 0, 1, 0, 0, 0, 8'h01, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 0, 1, 0, 8'(i * 16), 8'h00);
      if (i < 5) idle();
    end
    check("ovf_set", 8'(ovf), 8'd1);
    check("ovf_full", 8'(full), 8'd1);
    step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00); check("oret1", pc, 8'h42);
    step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00); check("oret2", pc, 8'h32);
    step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00); check("oret3", pc, 8'h22);
    step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00); check("oret4", pc, 8'h12);
    check("oret_empty", 8'(empty), 8'd1);
    step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00); check("unf_inc", pc, 8'h13);
    check("unf_set", 8'(unf), 8'd1);

    // Priority among ret/call/load
    do_reset();
    step(0, 0, 1, 0, 0, 0, 8'h32, 8'h00);
    step(0, 0, 0, 0, 1, 0, 8'h70, 8'h00);
    step(0, 0, 1, 0, 1, 1, 8'h90, 8'h00); check("ret_wins", pc, 8'h33);
    check("ret_wins_empty", 8'(empty), 8'd1);
    step(0, 0, 1, 0, 1, 0, 8'h50, 8'h00); check("call_load", pc, 8'h50);
    check("call_load_push", 8'(empty), 8'd0);
`else
    step(0, 0, 0, 0, 1, 0, 8'h40, 8'h00); check("call_as_load", pc, 8'h40);
    step(0, 0, 0, 0, 0, 1, 8'h00, 8'h00); check("ret_ignored", pc, 8'h41);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
           8'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
